// File: rtl/rr_arb_mux.sv
// rr_arb_mux: fixed-select / round-robin N:1 arbitrating mux with a registered output stage.
// Define RR_ARB_MUX_PARITY_EN to add the registered even-parity output OUT_PARITY.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH = 4,
    localparam int SW = $clog2(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH*WIDTH-1:0] IN_DATA,
    input  logic [NCH-1:0]       IN_VALID,
    output logic [NCH-1:0]       IN_READY,
    input  logic                 MODE,
    input  logic [SW-1:0]        SEL,
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic [SW-1:0]        OUT_CH,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
`ifdef RR_ARB_MUX_PARITY_EN
    ,
    output logic                 OUT_PARITY
`endif
);
    localparam int NP = 1 << SW;
    logic [SW-1:0] ptr, rr_idx, g;
    logic [NP-1:0] valid_pad;
    logic [WIDTH-1:0] sel_data;
    logic rr_hit, fx_hit, hit, ld, xfer;
    // zero-padding makes an out-of-range SEL look like an idle channel
    assign valid_pad = NP'(IN_VALID);
    assign fx_hit = valid_pad[SEL];
    // walk from farthest to nearest so the nearest valid channel after ptr wins
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (IN_VALID[(int'(ptr) + i) % NCH]) begin
                rr_hit = 1'b1;
                rr_idx = SW'((int'(ptr) + i) % NCH);
            end
        end
    end
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NCH; c++)
            if (SW'(c) == g) sel_data = IN_DATA[c*WIDTH +: WIDTH];
    end
    assign hit = MODE ? rr_hit : fx_hit;
    assign g = MODE ? rr_idx : SEL;
    assign ld = !OUT_VALID || OUT_READY;
    assign xfer = ld && hit && !RST;
    assign IN_READY = xfer ? (NCH'(1) << g) : '0;
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA <= '0;
            OUT_CH <= '0;
            ptr <= SW'(NCH - 1);
`ifdef RR_ARB_MUX_PARITY_EN
            OUT_PARITY <= 1'b0;
`endif
        end else if (ld) begin
            OUT_VALID <= hit;
            if (hit) begin
                OUT_DATA <= sel_data;
                OUT_CH <= g;
                ptr <= g;
`ifdef RR_ARB_MUX_PARITY_EN
                OUT_PARITY <= ^sel_data;
`endif
            end
        end
    end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vector table plus hand sequences for rr_arb_mux (NCH=4) and a NCH=3 instance.
module tb_rr_arb_mux;
    logic CLK = 1'b0, RST = 1'b1;
    logic [31:0] in_data;
    logic [3:0] in_valid, in_ready;
    logic mode, out_ready, out_valid;
    logic [1:0] sel, out_ch;
    logic [7:0] out_data;
    logic [23:0] d3;
    logic [2:0] v3, r3;
    logic m3, ov3;
    logic [1:0] s3, ch3;
    logic [7:0] od3;
`ifdef RR_ARB_MUX_PARITY_EN
    logic par, par3;
`endif
    int n_chk = 0, n_fail = 0;

    rr_arb_mux #(.WIDTH(8), .NCH(4)) dut (
        .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .MODE(mode), .SEL(sel), .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
`ifdef RR_ARB_MUX_PARITY_EN
        , .OUT_PARITY(par)
`endif
    );

    rr_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (
        .CLK(CLK), .RST(RST), .IN_DATA(d3), .IN_VALID(v3), .IN_READY(r3),
        .MODE(m3), .SEL(s3), .OUT_DATA(od3), .OUT_CH(ch3), .OUT_VALID(ov3),
        .OUT_READY(1'b1)
`ifdef RR_ARB_MUX_PARITY_EN
        , .OUT_PARITY(par3)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic rst;
        logic mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic ordy;
        logic [3:0] ir;
        logic ov;
        logic [1:0] och;
        logic [7:0] od;
    } vec_t;
    vec_t vt[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vt[0]  = '{1, 1, 0, 4'hF, 1, 4'h0, 0, 0, 8'h00};
        vt[1]  = '{1, 1, 0, 4'hF, 1, 4'h0, 0, 0, 8'h00};
        vt[2]  = '{0, 1, 0, 4'hF, 1, 4'h1, 1, 0, 8'h11};
        vt[3]  = '{0, 1, 0, 4'hF, 1, 4'h2, 1, 1, 8'h22};
        vt[4]  = '{0, 1, 0, 4'hF, 1, 4'h4, 1, 2, 8'hA5};
        vt[5]  = '{0, 1, 0, 4'hF, 1, 4'h8, 1, 3, 8'h07};
        vt[6]  = '{0, 1, 0, 4'hF, 1, 4'h1, 1, 0, 8'h11};
        vt[7]  = '{0, 1, 0, 4'hF, 1, 4'h2, 1, 1, 8'h22};
        vt[8]  = '{0, 0, 2, 4'hF, 1, 4'h4, 1, 2, 8'hA5};
        vt[9]  = '{0, 0, 2, 4'hB, 1, 4'h0, 0, 2, 8'hA5};
        vt[10] = '{0, 0, 2, 4'hB, 1, 4'h0, 0, 2, 8'hA5};
        vt[11] = '{0, 0, 0, 4'hB, 1, 4'h1, 1, 0, 8'h11};
        vt[12] = '{0, 1, 0, 4'hA, 1, 4'h2, 1, 1, 8'h22};
        vt[13] = '{0, 1, 0, 4'hA, 1, 4'h8, 1, 3, 8'h07};
        vt[14] = '{0, 1, 0, 4'hA, 1, 4'h2, 1, 1, 8'h22};
        vt[15] = '{0, 1, 0, 4'hA, 1, 4'h8, 1, 3, 8'h07};
        vt[16] = '{0, 1, 0, 4'hA, 0, 4'h0, 1, 3, 8'h07};
        vt[17] = '{0, 1, 0, 4'hA, 0, 4'h0, 1, 3, 8'h07};
        vt[18] = '{0, 1, 0, 4'hA, 0, 4'h0, 1, 3, 8'h07};
        vt[19] = '{0, 1, 0, 4'hA, 1, 4'h2, 1, 1, 8'h22};
        vt[20] = '{0, 1, 0, 4'hA, 1, 4'h8, 1, 3, 8'h07};
        vt[21] = '{0, 1, 0, 4'h0, 1, 4'h0, 0, 3, 8'h07};
        vt[22] = '{0, 1, 0, 4'h4, 1, 4'h4, 1, 2, 8'hA5};
        vt[23] = '{0, 0, 1, 4'hF, 0, 4'h0, 1, 2, 8'hA5};
        vt[24] = '{1, 1, 0, 4'hF, 0, 4'h0, 0, 0, 8'h00};
        vt[25] = '{0, 1, 0, 4'hF, 1, 4'h1, 1, 0, 8'h11};
        in_data = {8'h07, 8'hA5, 8'h22, 8'h11};
        d3 = {8'h33, 8'h5A, 8'hC3};
        v3 = 3'b000; m3 = 1'b0; s3 = 2'd0;
        for (int i = 0; i < 26; i++) begin
            @(negedge CLK);
            RST = vt[i].rst; mode = vt[i].mode; sel = vt[i].sel;
            in_valid = vt[i].valid; out_ready = vt[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vt[i].ir));
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d out_ch", i), 32'(out_ch), 32'(vt[i].och));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(vt[i].od));
        end
        // parity capture: 0x07 then 0x03 from channel 3
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            mode = 1'b0; sel = 2'd3; in_valid = 4'h8; out_ready = 1'b1;
            in_data[31:24] = k == 0 ? 8'h07 : 8'h03;
            #1;
            chk($sformatf("par%0d in_ready", k), 32'(in_ready), 32'h8);
            @(posedge CLK);
            #1;
            chk($sformatf("par%0d out_data", k), 32'(out_data), k == 0 ? 32'h07 : 32'h03);
            chk($sformatf("par%0d out_ch", k), 32'(out_ch), 32'd3);
`ifdef RR_ARB_MUX_PARITY_EN
            chk($sformatf("par%0d out_parity", k), 32'(par), k == 0 ? 32'd1 : 32'd0);
`endif
        end
        // NCH=3: SEL=3 is out of range, then SEL=2 is a normal grant
        @(negedge CLK);
        in_valid = 4'h0;
        m3 = 1'b0; s3 = 2'd3; v3 = 3'b111;
        #1;
        chk("n3 sel3 in_ready", 32'(r3), 32'h0);
        @(posedge CLK);
        #1;
        chk("n3 sel3 out_valid", 32'(ov3), 32'd0);
        @(negedge CLK);
        s3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 32'(r3), 32'h4);
        @(posedge CLK);
        #1;
        chk("n3 sel2 out_valid", 32'(ov3), 32'd1);
        chk("n3 sel2 out_ch", 32'(ch3), 32'd2);
        chk("n3 sel2 out_data", 32'(od3), 32'h33);
        // NCH=3 round-robin wraps from ch2 back to ch0
        @(negedge CLK);
        m3 = 1'b1;
        #1;
        chk("n3 rr in_ready", 32'(r3), 32'h1);
        @(posedge CLK);
        #1;
        chk("n3 rr out_ch", 32'(ch3), 32'd0);
        chk("n3 rr out_data", 32'(od3), 32'hC3);
        @(negedge CLK);
        v3 = 3'b000;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, legal range 1-32.
REQ-002 Parameter NCH, default 4: number of input channels, legal range 2-16; SW = $clog2(NCH).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 IN_DATA  input  NCH*WIDTH  channel c data in bits [c*WIDTH +: WIDTH].
REQ-006 IN_VALID  input  NCH  per-channel data-valid.
REQ-007 IN_READY  output  NCH  per-channel accept; combinational; one-hot or zero.
REQ-008 MODE  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-009 SEL  input  SW  channel index used in fixed-select mode.
REQ-010 OUT_DATA  output  WIDTH  registered selected data.
REQ-011 OUT_CH  output  SW  registered index of the channel that supplied OUT_DATA.
REQ-012 OUT_VALID  output  1  output register holds valid data.
REQ-013 OUT_READY  input  1  downstream accept.

Function
REQ-014 Load enable LD = !OUT_VALID || OUT_READY; the block arbitrates only when LD=1.
REQ-015 Fixed mode: the grant is SEL if IN_VALID[SEL]=1; otherwise there is no grant.
REQ-016 Fixed mode, SEL >= NCH (non-power-of-two NCH): no grant, and all IN_READY stay 0.
REQ-017 Round-robin mode: the grant is the first c with IN_VALID[c]=1, searching PTR+1, PTR+2, ... mod NCH, with PTR itself searched last.
REQ-018 PTR: SW-bit register, reset to NCH-1; updates to the granted index on every completed transfer, in either mode.
REQ-019 Transfer: IN_READY[g]=1 only when LD=1 and a grant g exists; on that edge OUT_DATA <= channel g data, OUT_CH <= g, OUT_VALID <= 1.
REQ-020 LD=1 with no grant: OUT_VALID <= 0 on the edge; OUT_DATA and OUT_CH hold.
REQ-021 LD=0 (OUT_VALID=1, OUT_READY=0): output holds stable; all IN_READY=0.
REQ-022 Latency is one cycle from input transfer to OUT_VALID; sustained throughput is one word per cycle with OUT_READY held at 1.
REQ-023 A MODE or SEL change affects only the next arbitration; held output is unaffected.
REQ-024 IN_READY depends only on IN_VALID, MODE, SEL, PTR, OUT_VALID and OUT_READY; it never depends on IN_DATA.

Reset
REQ-025 RST=1 on a clock edge: OUT_VALID=0, OUT_DATA=0, OUT_CH=0, PTR=NCH-1; OUT_PARITY=0 when present.
REQ-026 While RST=1, all IN_READY=0 and no transfer occurs.
REQ-027 Reset asserted mid-stream discards held data without completing a handshake.

Configuration
REQ-028 Macro RR_ARB_MUX_PARITY_EN defined: adds output OUT_PARITY, 1 bit, registered with OUT_DATA, equal to the XOR of the captured data (even parity), for the UART Tx parity stage.
REQ-029 Macro undefined: the OUT_PARITY port and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Reset: RST=1 for 2 cycles with all IN_VALID=1 -> IN_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_CH=0.
REQ-031 Fixed mode, NCH=4, SEL=2, IN_VALID=4'b1111, ch2=0xA5, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_DATA=0xA5, OUT_CH=2.
REQ-032 Round-robin, all channels valid, OUT_READY=1 for 6 cycles -> OUT_CH sequence 0,1,2,3,0,1.
REQ-033 Round-robin, IN_VALID=4'b1010 -> grants 1,3,1,3; then OUT_READY=0 for 3 cycles -> output holds, IN_READY=0; then OUT_READY=1 -> stream resumes with no loss or duplication.
REQ-034 Transfer of 0x07 with RR_ARB_MUX_PARITY_EN defined -> OUT_PARITY=1; transfer of 0x03 -> OUT_PARITY=0.
REQ-035 RST=1 while OUT_VALID=1 and OUT_READY=0 -> next cycle OUT_VALID=0, PTR=NCH-1, and the first post-reset round-robin grant is channel 0.
